// File: rtl/esm_pkg.sv
// Shared types and constants for the ESM receiver report path.
package esm_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } esm_report_arbiter_state_t;

  localparam int unsigned esm_report_max_packet_words = 1024;

endpackage : esm_pkg

// File: rtl/esm_rr_select.sv
// Combinational round-robin pick: first asserted request after last_grant, wrapping.
module esm_rr_select #(
  parameter int unsigned NUM_INPUTS = 3
) (
  input  logic [NUM_INPUTS-1:0]         request,
  input  logic [$clog2(NUM_INPUTS)-1:0] last_grant,
  output logic                          any_request,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_index
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);

  int unsigned idx;
  logic        found;

  // Scan indices last_grant+1 .. last_grant+NUM_INPUTS, taking the first requester.
  always_comb begin
    any_request = |request;
    grant_index = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= NUM_INPUTS) begin
        idx = idx - NUM_INPUTS;
      end
      if (!found && request[IDX_W'(idx)]) begin
        found       = 1'b1;
        grant_index = IDX_W'(idx);
      end
    end
  end

endmodule : esm_rr_select

// File: rtl/esm_report_arbiter.sv
// Packet-atomic round-robin merge of report sources onto one registered AXI-stream.
// Overlong packets are cut at MAX_PACKET_WORDS and their remainder is drained.
module esm_report_arbiter
  import esm_pkg::*;
#(
  parameter int unsigned NUM_INPUTS       = 3,
  parameter int unsigned AXI_DATA_WIDTH   = 32,
  parameter int unsigned MAX_PACKET_WORDS = esm_report_max_packet_words
) (
  input  logic                                 Clk,
  input  logic                                 Resetn,
  input  logic [NUM_INPUTS-1:0]                S_axis_valid,
  input  logic [NUM_INPUTS*AXI_DATA_WIDTH-1:0] S_axis_data,
  input  logic [NUM_INPUTS-1:0]                S_axis_last,
  output logic [NUM_INPUTS-1:0]                S_axis_ready,
  output logic                                 M_axis_valid,
  output logic [AXI_DATA_WIDTH-1:0]            M_axis_data,
  output logic                                 M_axis_last,
  input  logic                                 M_axis_ready,
  output logic [$clog2(NUM_INPUTS)-1:0]        Grant_index,
  output logic                                 Grant_active,
  output logic                                 Error_truncated
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);
  localparam int unsigned CNT_W = $clog2(MAX_PACKET_WORDS + 1);

  esm_report_arbiter_state_t state_q, state_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [IDX_W-1:0]          last_grant_q, last_grant_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      m_valid_q, m_valid_d;
  logic [AXI_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                      m_last_q, m_last_d;
  logic                      err_q, err_d;

  logic [AXI_DATA_WIDTH-1:0] src_data [NUM_INPUTS];
  logic                      any_request;
  logic [IDX_W-1:0]          pick;
  logic                      out_free;
  logic                      sel_valid;
  logic                      sel_last;
  logic [AXI_DATA_WIDTH-1:0] sel_data;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign src_data[i] = S_axis_data[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

  esm_rr_select #(
    .NUM_INPUTS(NUM_INPUTS)
  ) u_rr_select (
    .request     (S_axis_valid),
    .last_grant  (last_grant_q),
    .any_request (any_request),
    .grant_index (pick)
  );

  assign out_free  = !m_valid_q || M_axis_ready;
  assign sel_valid = S_axis_valid[grant_q];
  assign sel_last  = S_axis_last[grant_q];
  assign sel_data  = src_data[grant_q];

  // Next-state, source ready, output-register load and word counting.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    err_d        = 1'b0;
    S_axis_ready = '0;

    // A consumed word empties the stage unless a new transfer reloads it below.
    if (out_free) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (any_request) begin
          grant_d      = pick;
          last_grant_d = pick;
          count_d      = '0;
          state_d      = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        S_axis_ready[grant_q] = out_free;
        if (sel_valid && out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = sel_data;
          m_last_d  = sel_last;
          if (sel_last) begin
            count_d = '0;
            state_d = S_IDLE;
          end else if (count_q == CNT_W'(MAX_PACKET_WORDS - 1)) begin
            // Final legal word without last: close the packet here and drop the rest.
            m_last_d = 1'b1;
            err_d    = 1'b1;
            count_d  = '0;
            state_d  = S_DRAIN;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        S_axis_ready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, grant, counter and output register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_INPUTS - 1);
      count_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      err_q        <= err_d;
    end
  end

  assign M_axis_valid    = m_valid_q;
  assign M_axis_data     = m_data_q;
  assign M_axis_last     = m_last_q;
  assign Grant_index     = grant_q;
  assign Grant_active    = (state_q != S_IDLE);
  assign Error_truncated = err_q;

endmodule : esm_report_arbiter

// File: tb/tb_esm_report_arbiter.sv
// Directed self-checking bench for esm_report_arbiter (3 sources, 32-bit, max 8 words).
module tb_esm_report_arbiter;

  localparam int unsigned N    = 3;
  localparam int unsigned W    = 32;
  localparam int unsigned MAXW = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     s_valid;
  logic [N*W-1:0]   s_data;
  logic [N-1:0]     s_last;
  logic [N-1:0]     s_ready;
  logic             m_valid;
  logic [W-1:0]     m_data;
  logic             m_last;
  logic             m_ready;
  logic [1:0]       grant_index;
  logic             grant_active;
  logic             err;

  esm_report_arbiter #(
    .NUM_INPUTS      (N),
    .AXI_DATA_WIDTH  (W),
    .MAX_PACKET_WORDS(MAXW)
  ) dut (
    .Clk            (clk),
    .Resetn         (rstn),
    .S_axis_valid   (s_valid),
    .S_axis_data    (s_data),
    .S_axis_last    (s_last),
    .S_axis_ready   (s_ready),
    .M_axis_valid   (m_valid),
    .M_axis_data    (m_data),
    .M_axis_last    (m_last),
    .M_axis_ready   (m_ready),
    .Grant_index    (grant_index),
    .Grant_active   (grant_active),
    .Error_truncated(err)
  );

  always #5 clk = ~clk;

  // Source queues hold {last, data}; head is presented while non-empty.
  logic [W:0]  srcq [N][$];
  logic [W:0]  expq [N][$];
  logic [W:0]  outq [$];
  logic [W:0]  expl [$];
  logic [N-1:0] hs;
  int unsigned err_cnt = 0;
  int unsigned ready_mode = 1;  // 0: hold low, 1: hold high, 2: 80% random
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] word(input int unsigned src, input int unsigned seq,
                                      input logic last);
    return {last, 8'(src), 24'(seq)};
  endfunction

  // Sample handshakes and the merged stream mid-cycle, away from the clock edge.
  initial begin : monitor
    hs = '0;
    forever begin
      @(negedge clk);
      hs = s_valid & s_ready;
      if (m_valid && m_ready) outq.push_back({m_last, m_data});
      if (err) err_cnt++;
    end
  end

  // Retire accepted source words and present the next queue heads.
  initial begin : driver
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      end
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 99) < 80);
      endcase
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() > 0) begin
          s_valid[i]       = 1'b1;
          s_last[i]        = srcq[i][0][W];
          s_data[i*W +: W] = srcq[i][0][W-1:0];
        end else begin
          s_valid[i] = 1'b0;
          s_last[i]  = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic wait_words(input string tag, input int unsigned n, input int unsigned budget);
    int unsigned c;
    c = 0;
    while (outq.size() < n && c < budget) begin
      step();
      c++;
    end
    chk(tag, 64'(outq.size()), 64'(n));
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, 64'(outq.size()), 64'(expl.size()));
    for (int i = 0; i < expl.size() && i < outq.size(); i++) begin
      chk($sformatf("%s[%0d]", tag, i), 64'(outq[i]), 64'(expl[i]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mvalid"}, 64'(m_valid), 64'(0));
    chk({tag, "_mdata"},  64'(m_data), 64'(0));
    chk({tag, "_mlast"},  64'(m_last), 64'(0));
    chk({tag, "_gact"},   64'(grant_active), 64'(0));
    chk({tag, "_gidx"},   64'(grant_index), 64'(0));
    chk({tag, "_err"},    64'(err), 64'(0));
    chk({tag, "_sready"}, 64'(s_ready), 64'(0));
  endtask

  initial begin : stimulus
    int unsigned e0;
    int unsigned total;
    int unsigned len;
    int unsigned mism;
    int unsigned viol;
    int unsigned left;
    int unsigned seqc [N];
    logic [7:0]  cur_src;
    logic        in_pkt;
    logic [W:0]  w;
    logic [7:0]  s;

    rstn = 1'b0;
    ready_mode = 1;
    step(); step(); step();
    check_all_zero("reset");
    rstn = 1'b1;
    step();

    // Test 1: src0 4-word packet, 2-cycle first latency, back-to-back output.
    for (int j = 0; j < 4; j++) srcq[0].push_back({(j == 3), 32'(32'h10 + j)});
    step();
    chk("t1_lat_mvalid", 64'(m_valid), 64'(0));
    chk("t1_gact", 64'(grant_active), 64'(1));
    chk("t1_gidx", 64'(grant_index), 64'(0));
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("t1_valid%0d", j), 64'(m_valid), 64'(1));
      chk($sformatf("t1_data%0d", j), 64'(m_data), 64'(32'h10 + j));
      chk($sformatf("t1_last%0d", j), 64'(m_last), 64'(j == 3));
    end
    step();
    chk("t1_end_mvalid", 64'(m_valid), 64'(0));
    chk("t1_end_gact", 64'(grant_active), 64'(0));

    // Test 2: all sources hold two 3-word packets; grants rotate 0,1,2,0,1,2.
    do_reset();
    outq.delete();
    expl.delete();
    for (int src = 0; src < N; src++)
      for (int q = 0; q < 6; q++) srcq[src].push_back(word(src, q, (q % 3) == 2));
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 3; j++) expl.push_back(word(k % 3, (k / 3) * 3 + j, j == 2));
    wait_words("t2_wait", 18, 300);
    cmp_stream("t2");

    // Test 3: 200 random-length packets with 80% downstream ready.
    outq.delete();
    total = 0;
    for (int i = 0; i < N; i++) begin
      seqc[i] = 0;
      expq[i].delete();
    end
    for (int k = 0; k < 200; k++) begin
      len = $urandom_range(1, MAXW);
      for (int j = 0; j < int'(len); j++) begin
        w = word(k % 3, seqc[k % 3], j == int'(len) - 1);
        seqc[k % 3]++;
        srcq[k % 3].push_back(w);
        expq[k % 3].push_back(w);
      end
      total += len;
    end
    ready_mode = 2;
    wait_words("t3_wait", total, 20000);
    ready_mode = 1;
    mism = 0;
    viol = 0;
    in_pkt = 1'b0;
    cur_src = '0;
    for (int i = 0; i < outq.size(); i++) begin
      s = outq[i][W-1:W-8];
      if (in_pkt && s != cur_src) viol++;
      cur_src = s;
      in_pkt = !outq[i][W];
      if (s < N && expq[s].size() > 0) begin
        if (outq[i] !== expq[s].pop_front()) mism++;
      end else begin
        mism++;
      end
    end
    left = expq[0].size() + expq[1].size() + expq[2].size();
    chk("t3_mismatches", 64'(mism), 64'(0));
    chk("t3_interleave", 64'(viol), 64'(0));
    chk("t3_leftover", 64'(left), 64'(0));

    // Test 4: exact-max packet on src0 is legal; src1 12 words truncated to 8; src2 intact.
    do_reset();
    outq.delete();
    expl.delete();
    e0 = err_cnt;
    for (int j = 0; j < 8; j++)  srcq[0].push_back(word(0, j, j == 7));
    for (int j = 0; j < 12; j++) srcq[1].push_back(word(1, j, j == 11));
    for (int j = 0; j < 3; j++)  srcq[2].push_back(word(2, j, j == 2));
    for (int j = 0; j < 8; j++)  expl.push_back(word(0, j, j == 7));
    for (int j = 0; j < 8; j++)  expl.push_back(word(1, j, j == 7));
    for (int j = 0; j < 3; j++)  expl.push_back(word(2, j, j == 2));
    wait_words("t4_wait", 19, 400);
    step(); step();
    cmp_stream("t4");
    chk("t4_err_pulses", 64'(err_cnt - e0), 64'(1));
    chk("t4_src1_drained", 64'(srcq[1].size()), 64'(0));

    // Test 5: single-word packets from src0 and src1 alternate.
    outq.delete();
    expl.delete();
    for (int j = 0; j < 2; j++) begin
      srcq[0].push_back(word(0, j, 1'b1));
      srcq[1].push_back(word(1, j, 1'b1));
      expl.push_back(word(0, j, 1'b1));
      expl.push_back(word(1, j, 1'b1));
    end
    wait_words("t5_wait", 4, 100);
    cmp_stream("t5");

    // Test 6: one-cycle reset mid-packet of src2, then src0 wins first.
    outq.delete();
    for (int j = 0; j < 5; j++) srcq[2].push_back(word(2, j, j == 4));
    wait_words("t6_wait_mid", 2, 100);
    rstn = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    step();
    check_all_zero("t6_reset");
    rstn = 1'b1;
    step();
    outq.delete();
    expl.delete();
    for (int i = 0; i < N; i++) begin
      srcq[i].push_back(word(i, 100, 1'b1));
      expl.push_back(word(i, 100, 1'b1));
    end
    wait_words("t6_wait", 3, 100);
    cmp_stream("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_esm_report_arbiter
